// File: rtl/vanilla_trace_buffer_pkg.sv
// Shared types and record layout for the vanilla core trace capture buffer.
//
// Record layout, MSB to LSB:
//   {stall_cnt, pc, instr, chan[0], chan[1], ... chan[num_wb_chan-1]}
// where each channel field is {wb_v, wb_addr, wb_data}.
package bsg_vanilla_trace_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StPost   = 2'd2,
        StFrozen = 2'd3
    } trace_state_e;

    typedef enum logic {
        ModeStream  = 1'b0,
        ModeTrigger = 1'b1
    } trace_mode_e;

    localparam int unsigned DropCntWidth = 16;

    function automatic int unsigned trace_rec_width(input int unsigned data_width,
                                                    input int unsigned reg_addr_width,
                                                    input int unsigned num_wb_chan,
                                                    input int unsigned stall_cnt_width);
        return stall_cnt_width + 2 * data_width
               + num_wb_chan * (1 + reg_addr_width + data_width);
    endfunction

endpackage

// File: rtl/vanilla_trace_buffer_if.sv
// Readout port of the trace buffer: valid/yumi handshake carrying the oldest record.
//   master: buffer side, drives rd_v/rd_data, receives rd_yumi
//   slave : host side, receives rd_v/rd_data, drives rd_yumi
interface vanilla_trace_buffer_if
    import bsg_vanilla_trace_pkg::*;
#(
    parameter int unsigned rec_width_p = trace_rec_width(32, 5, 2, 12)
) ();

    logic                   rd_v;
    logic [rec_width_p-1:0] rd_data;
    logic                   rd_yumi;

    modport master (output rd_v, output rd_data, input rd_yumi);
    modport slave  (input rd_v, input rd_data, output rd_yumi);

endinterface

// File: rtl/vanilla_trace_buffer_mem.sv
// Simple 1-write 1-read register-file storage for trace records.
// Read is asynchronous; a write is visible on the read port from the next cycle on
// (no same-cycle write-to-read bypass).
//   w_clk_i  : write clock
//   w_v_i    : write enable
//   w_addr_i : write address
//   w_data_i : write data
//   r_addr_i : read address
//   r_data_o : read data (combinational)
module bsg_mem_1r1w #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 4
) (
    input  logic                       w_clk_i,
    input  logic                       w_v_i,
    input  logic [$clog2(els_p)-1:0]   w_addr_i,
    input  logic [width_p-1:0]         w_data_i,
    input  logic [$clog2(els_p)-1:0]   r_addr_i,
    output logic [width_p-1:0]         r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/vanilla_trace_buffer.sv
// Trace capture buffer for one vanilla core, fed from writeback.
// Stream mode: FIFO drained via rd_io, overflow counted in drop_cnt_o.
// Trigger mode: circular overwrite until retire PC matches trig_pc_i, then
// post_count_i more records, then frozen for readout.
//   clk_i, reset_n_i          : clock, async active-low reset
//   mode_i/arm_i/disarm_i     : control (mode sampled on arm)
//   trig_pc_i, post_count_i   : trigger configuration
//   stall_i, retire_*, wb_*   : writeback-stage trace inputs
//   rd_io                     : record readout (valid/yumi)
//   state_o, count_o          : FSM state and occupancy
//   drop_cnt_o                : saturating stream-mode drop count
module vanilla_trace_buffer
    import bsg_vanilla_trace_pkg::*;
#(
    parameter int unsigned depth_p           = 64,
    parameter int unsigned num_wb_chan_p     = 2,
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned reg_addr_width_p  = 5,
    parameter int unsigned stall_cnt_width_p = 12,
    parameter int unsigned post_cnt_width_p  = 8
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       mode_i,
    input  logic                                       arm_i,
    input  logic                                       disarm_i,
    input  logic [data_width_p-1:0]                    trig_pc_i,
    input  logic [post_cnt_width_p-1:0]                post_count_i,
    input  logic                                       stall_i,
    input  logic                                       retire_v_i,
    input  logic [data_width_p-1:0]                    retire_pc_i,
    input  logic [data_width_p-1:0]                    retire_instr_i,
    input  logic [num_wb_chan_p-1:0]                   wb_v_i,
    input  logic [num_wb_chan_p*reg_addr_width_p-1:0]  wb_addr_i,
    input  logic [num_wb_chan_p*data_width_p-1:0]      wb_data_i,
    vanilla_trace_buffer_if.master                     rd_io,
    output logic [1:0]                                 state_o,
    output logic [$clog2(depth_p+1)-1:0]               count_o,
    output logic [DropCntWidth-1:0]                    drop_cnt_o
);

    localparam int unsigned PtrW  = $clog2(depth_p);
    localparam int unsigned CntW  = $clog2(depth_p + 1);
    localparam int unsigned ChanW = 1 + reg_addr_width_p + data_width_p;
    localparam int unsigned RecW  = trace_rec_width(data_width_p, reg_addr_width_p,
                                                    num_wb_chan_p, stall_cnt_width_p);

    trace_state_e                  state_q, state_d;
    trace_mode_e                   mode_q, mode_d;
    logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]               count_q, count_d;
    logic [DropCntWidth-1:0]       drop_q, drop_d;
    logic [stall_cnt_width_p-1:0]  stall_q, stall_d;
    logic [post_cnt_width_p-1:0]   post_q, post_d;

    logic                          we, rd_v, pop, full;
    logic [num_wb_chan_p*ChanW-1:0] chan_bits;
    logic [RecW-1:0]               rec, rd_data;

    // Channel 0 sits just below instr; unwritten channels are fully zeroed.
    always_comb begin
        chan_bits = '0;
        for (int unsigned i = 0; i < num_wb_chan_p; i++) begin
            if (wb_v_i[i]) begin
                chan_bits[(num_wb_chan_p-1-i)*ChanW +: ChanW] =
                    {1'b1, wb_addr_i[i*reg_addr_width_p +: reg_addr_width_p],
                     wb_data_i[i*data_width_p +: data_width_p]};
            end
        end
    end

    assign rec = {stall_q, retire_pc_i, retire_instr_i, chan_bits};

    // Stall counter runs in every state; a retire hands its value to the record.
    always_comb begin
        stall_d = stall_q;
        if (retire_v_i) begin
            stall_d = '0;
        end else if (stall_i && !(&stall_q)) begin
            stall_d = stall_q + stall_cnt_width_p'(1);
        end
    end

    assign full = (count_q == CntW'(depth_p));
    assign rd_v = (count_q != '0) &&
                  ((state_q == StArmed && mode_q == ModeStream) || state_q == StFrozen);
    assign pop  = rd_v && rd_io.rd_yumi;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        post_d   = post_q;
        we       = 1'b0;
        if (disarm_i) begin
            // drop_q is intentionally kept so the host can still read it after disarm.
            state_d  = StIdle;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm_i) begin
                        state_d  = StArmed;
                        mode_d   = trace_mode_e'(mode_i);
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                        drop_d   = '0;
                    end
                end
                StArmed, StPost: begin
                    if (state_q == StArmed && mode_q == ModeStream) begin
                        if (retire_v_i) begin
                            // A same-cycle pop frees a slot even when full.
                            if (!full || pop) begin
                                we       = 1'b1;
                                wr_ptr_d = wr_ptr_q + PtrW'(1);
                            end else if (!(&drop_q)) begin
                                drop_d = drop_q + DropCntWidth'(1);
                            end
                        end
                        if (pop) begin
                            rd_ptr_d = rd_ptr_q + PtrW'(1);
                        end
                        count_d = count_q + CntW'(we) - CntW'(pop);
                    end else if (retire_v_i) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                        if (full) begin
                            rd_ptr_d = rd_ptr_q + PtrW'(1);
                        end else begin
                            count_d = count_q + CntW'(1);
                        end
                        if (state_q == StArmed) begin
                            if (retire_pc_i == trig_pc_i) begin
                                if (post_count_i == '0) begin
                                    state_d = StFrozen;
                                end else begin
                                    post_d  = post_count_i;
                                    state_d = StPost;
                                end
                            end
                        end else begin
                            post_d = post_q - post_cnt_width_p'(1);
                            if (post_q == post_cnt_width_p'(1)) begin
                                state_d = StFrozen;
                            end
                        end
                    end
                end
                StFrozen: begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PtrW'(1);
                        count_d  = count_q - CntW'(1);
                        if (count_q == CntW'(1)) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            mode_q   <= ModeStream;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            stall_q  <= '0;
            post_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            stall_q  <= stall_d;
            post_q   <= post_d;
        end
    end

    bsg_mem_1r1w #(
        .width_p (RecW),
        .els_p   (depth_p)
    ) u_mem (
        .w_clk_i  (clk_i),
        .w_v_i    (we),
        .w_addr_i (wr_ptr_q),
        .w_data_i (rec),
        .r_addr_i (rd_ptr_q),
        .r_data_o (rd_data)
    );

    assign rd_io.rd_v    = rd_v;
    assign rd_io.rd_data = rd_data;
    assign state_o       = 2'(state_q);
    assign count_o       = count_q;
    assign drop_cnt_o    = drop_q;

    // Host must only pop when a record is offered.
    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) rd_io.rd_yumi |-> rd_v);

endmodule

// File: tb/tb_vanilla_trace_buffer.sv
module tb_vanilla_trace_buffer;
    import bsg_vanilla_trace_pkg::*;

    localparam int unsigned RecW  = 152;  // 12 + 32 + 32 + 2*(1+5+32)
    localparam int unsigned RecWs = 143;  // same with a 3-bit stall counter

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mode, arm, disarm, stall, retire_v;
    logic [31:0] trig_pc, retire_pc, retire_instr;
    logic [7:0]  post_count;
    logic [1:0]  wb_v;
    logic [9:0]  wb_addr;
    logic [63:0] wb_data;
    logic [1:0]  state, state_s;
    logic [2:0]  count, count_s;
    logic [15:0] drop, drop_s;

    int total = 0;
    int bad   = 0;
    logic [RecW-1:0] exp_q[$];

    vanilla_trace_buffer_if #(.rec_width_p(RecW))  rd_if ();
    vanilla_trace_buffer_if #(.rec_width_p(RecWs)) rd_if_s ();

    always #5 clk = ~clk;

    vanilla_trace_buffer #(
        .depth_p(4), .num_wb_chan_p(2), .data_width_p(32), .reg_addr_width_p(5),
        .stall_cnt_width_p(12), .post_cnt_width_p(8)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .mode_i(mode), .arm_i(arm), .disarm_i(disarm),
        .trig_pc_i(trig_pc), .post_count_i(post_count), .stall_i(stall),
        .retire_v_i(retire_v), .retire_pc_i(retire_pc), .retire_instr_i(retire_instr),
        .wb_v_i(wb_v), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .rd_io(rd_if),
        .state_o(state), .count_o(count), .drop_cnt_o(drop)
    );

    vanilla_trace_buffer #(
        .depth_p(4), .num_wb_chan_p(2), .data_width_p(32), .reg_addr_width_p(5),
        .stall_cnt_width_p(3), .post_cnt_width_p(8)
    ) dut_s (
        .clk_i(clk), .reset_n_i(reset_n), .mode_i(mode), .arm_i(arm), .disarm_i(disarm),
        .trig_pc_i(trig_pc), .post_count_i(post_count), .stall_i(stall),
        .retire_v_i(retire_v), .retire_pc_i(retire_pc), .retire_instr_i(retire_instr),
        .wb_v_i(wb_v), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .rd_io(rd_if_s),
        .state_o(state_s), .count_o(count_s), .drop_cnt_o(drop_s)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    function automatic logic [RecW-1:0] mk_rec(input logic [11:0] st, input logic [31:0] pc,
                                               input logic v0, input logic [4:0] a0,
                                               input logic [31:0] d0, input logic v1,
                                               input logic [4:0] a1, input logic [31:0] d1);
        logic [37:0] c0, c1;
        c0 = v0 ? {1'b1, a0, d0} : 38'd0;
        c1 = v1 ? {1'b1, a1, d1} : 38'd0;
        return {st, pc, instr_of(pc), c0, c1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one retire for one cycle; unwritten channels carry garbage on purpose.
    task automatic do_retire(input logic [31:0] pc, input logic [1:0] v,
                             input logic [4:0] a0, input logic [31:0] d0,
                             input logic [4:0] a1, input logic [31:0] d1);
        retire_v     = 1'b1;
        retire_pc    = pc;
        retire_instr = instr_of(pc);
        wb_v         = v;
        wb_addr      = {a1, a0};
        wb_data      = {d1, d0};
        tick();
        retire_v = 1'b0;
        wb_v     = 2'b00;
    endtask

    // Scoreboard monitor: every accepted pop is checked against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && rd_if.rd_v && rd_if.rd_yumi) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got=%h", rd_if.rd_data);
            end else begin
                logic [RecW-1:0] e;
                e = exp_q.pop_front();
                if (rd_if.rd_data !== e) begin
                    bad++;
                    $display("FAIL rec got=%h exp=%h", rd_if.rd_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; mode = 1'b0; arm = 1'b0; disarm = 1'b0; stall = 1'b0;
        retire_v = 1'b0; trig_pc = '0; post_count = '0; retire_pc = '0;
        retire_instr = '0; wb_v = '0; wb_addr = '0; wb_data = '0;
        rd_if.rd_yumi = 1'b0; rd_if_s.rd_yumi = 1'b0;
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_rd_v", 32'(rd_if.rd_v), 0);
        reset_n = 1'b1;
        tick();

        // Stream mode basic
        mode = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_state", 32'(state), 1);
        exp_q.push_back(mk_rec(0, 32'h100, 1, 5'd5, 32'h11, 0, 0, 0));
        do_retire(32'h100, 2'b01, 5'd5, 32'h11, 5'd3, 32'hDEAD);
        exp_q.push_back(mk_rec(0, 32'h104, 1, 5'd6, 32'h22, 1, 5'd9, 32'h3F80_0000));
        do_retire(32'h104, 2'b11, 5'd6, 32'h22, 5'd9, 32'h3F80_0000);
        exp_q.push_back(mk_rec(0, 32'h108, 1, 5'd7, 32'h33, 0, 0, 0));
        do_retire(32'h108, 2'b01, 5'd7, 32'h33, 5'd31, 32'hBEEF);
        chk("s_count3", 32'(count), 3);
        chk("s_rd_v", 32'(rd_if.rd_v), 1);
        chk("s_head_pc", rd_if.rd_data[139:108], 32'h100);
        chk("s_head_wb0_addr", 32'(rd_if.rd_data[74:70]), 5);
        chk("s_head_wb0_data", rd_if.rd_data[69:38], 32'h11);
        rd_if.rd_yumi = 1'b1;
        repeat (3) tick();
        rd_if.rd_yumi = 1'b0;
        chk("s_count0", 32'(count), 0);
        chk("s_rd_v0", 32'(rd_if.rd_v), 0);

        // Stream mode overflow
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(mk_rec(0, 32'h500 + 32'(4 * i), 0, 0, 0, 0, 0, 0));
            do_retire(32'h500 + 32'(4 * i), 2'b00, 5'd1, 32'h1, 5'd2, 32'h2);
        end
        chk("full_count", 32'(count), 4);
        chk("full_drop", 32'(drop), 2);
        exp_q.push_back(mk_rec(0, 32'h600, 1, 5'd10, 32'hA5A5, 0, 0, 0));
        rd_if.rd_yumi = 1'b1;
        do_retire(32'h600, 2'b01, 5'd10, 32'hA5A5, 5'd0, 32'h0);
        rd_if.rd_yumi = 1'b0;
        chk("pushpop_count", 32'(count), 4);
        chk("pushpop_drop", 32'(drop), 2);
        rd_if.rd_yumi = 1'b1;
        repeat (4) tick();
        rd_if.rd_yumi = 1'b0;
        chk("drain_count", 32'(count), 0);
        disarm = 1'b1; tick(); disarm = 1'b0;
        chk("disarm_state", 32'(state), 0);
        chk("disarm_drop_held", 32'(drop), 2);

        // Trigger mode
        mode = 1'b1; trig_pc = 32'h200; post_count = 8'd2;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t_arm_drop", 32'(drop), 0);
        chk("t_arm_rd_v", 32'(rd_if.rd_v), 0);
        for (int i = 0; i < 10; i++) begin
            do_retire(32'h1F0 + 32'(4 * i), 2'b00, 5'd31, 32'hFFFF_FFFF, 5'd17, 32'h1234);
            if (i == 4) chk("t_post", 32'(state), 2);
        end
        chk("t_frozen", 32'(state), 3);
        chk("t_count", 32'(count), 4);
        chk("t_rd_v", 32'(rd_if.rd_v), 1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk_rec(0, 32'h1FC + 32'(4 * i), 0, 0, 0, 0, 0, 0));
        end
        rd_if.rd_yumi = 1'b1;
        repeat (4) tick();
        rd_if.rd_yumi = 1'b0;
        chk("t_idle", 32'(state), 0);
        chk("t_count0", 32'(count), 0);

        // Stall counting and saturation
        disarm = 1'b1; tick(); disarm = 1'b0;
        mode = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
        stall = 1'b1; repeat (5) tick(); stall = 1'b0;
        exp_q.push_back(mk_rec(12'd5, 32'h400, 0, 0, 0, 0, 0, 0));
        do_retire(32'h400, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        stall = 1'b1; repeat (10) tick(); stall = 1'b0;
        exp_q.push_back(mk_rec(12'd10, 32'h404, 0, 0, 0, 0, 0, 0));
        do_retire(32'h404, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("sat_count", 32'(count_s), 2);
        chk("sat_first", 32'(rd_if_s.rd_data[142:140]), 5);
        rd_if.rd_yumi = 1'b1; rd_if_s.rd_yumi = 1'b1;
        tick();
        rd_if_s.rd_yumi = 1'b0;
        chk("sat_second", 32'(rd_if_s.rd_data[142:140]), 7);
        tick();
        rd_if.rd_yumi = 1'b0;
        chk("stall_drain", 32'(count), 0);

        // Disarm wins over a same-cycle capture in POST
        disarm = 1'b1; tick(); disarm = 1'b0;
        mode = 1'b1; trig_pc = 32'h300; post_count = 8'd3;
        arm = 1'b1; tick(); arm = 1'b0;
        do_retire(32'h2F0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        do_retire(32'h300, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("d_post", 32'(state), 2);
        chk("d_count2", 32'(count), 2);
        disarm = 1'b1;
        do_retire(32'h304, 2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
        disarm = 1'b0;
        chk("d_idle", 32'(state), 0);
        chk("d_count0", 32'(count), 0);
        chk("d_rd_v", 32'(rd_if.rd_v), 0);

        // Async reset mid-POST
        arm = 1'b1; tick(); arm = 1'b0;
        do_retire(32'h300, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("r_post", 32'(state), 2);
        chk("r_count1", 32'(count), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_state", 32'(state), 0);
        chk("r_count", 32'(count), 0);
        chk("r_rd_v", 32'(rd_if.rd_v), 0);
        chk("r_state_s", 32'(state_s), 0);
        chk("r_count_s", 32'(count_s), 0);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vanilla_trace_buffer.md
Name: vanilla_trace_buffer

Overview:
Hardware trace capture buffer for one vanilla core, fed by the writeback stage. Each retired instruction becomes a packed record holding PC, instruction, per-channel RF writes and a preceding stall-cycle count, stored in an on-chip ring. It runs in one of two modes: stream mode (FIFO drained by the host through a valid/yumi port) or trigger mode (circular overwrite until a PC match, then a fixed post-trigger window, then freeze for readout). Replaces the simulation-only $fwrite trace with a synthesizable capture path.

Parameters:
depth_p, 64, ring entries; must be a power of 2, >= 2
num_wb_chan_p, 2, RF write channels per record (0 = int, 1 = fp)
data_width_p, 32, PC, instruction and RF write data width
reg_addr_width_p, 5, RF address width
stall_cnt_width_p, 12, saturating stall counter width
post_cnt_width_p, 8, width of the post-trigger count

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
mode_i  in  1  0 = stream, 1 = trigger; sampled on arm
arm_i  in  1  pulse; effective only in IDLE
disarm_i  in  1  pulse; forces IDLE from any state
trig_pc_i  in  data_width_p  trigger PC
post_count_i  in  post_cnt_width_p  records captured after the trigger record
stall_i  in  1  core pipeline stalled this cycle
retire_v_i  in  1  instruction retires this cycle
retire_pc_i  in  data_width_p  retiring PC
retire_instr_i  in  data_width_p  retiring instruction
wb_v_i  in  num_wb_chan_p  per-channel RF write valid
wb_addr_i  in  num_wb_chan_p*reg_addr_width_p  per-channel RF write address
wb_data_i  in  num_wb_chan_p*data_width_p  per-channel RF write data (fp un-recoded)
rd_v_o  out  1  record available
rd_data_o  out  trace_rec_width  oldest record
rd_yumi_i  in  1  pop; legal only when rd_v_o
state_o  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
count_o  out  clog2(depth_p+1)  occupied entries
drop_cnt_o  out  16  saturating count of records dropped in stream mode

Behaviour:
- Reset (async assert, sync release): state IDLE; rd_pointer, wr_pointer, count_o, drop_cnt_o, stall counter and post counter all 0; rd_v_o 0.
- Record = {stall_cnt, pc, instr, per channel {wb_v, wb_addr, wb_data}}. Unwritten channels have wb_v=0 and addr/data zeroed.
- Stall counter: +1 on each cycle with stall_i & ~retire_v_i; saturates at all-ones. On a retire cycle the record takes the current value and the counter clears to 0. The counter runs in every state.
- A capture happens on retire_v_i in ARMED or POST. Records are written at wr_pointer, and the record is visible on rd_data_o one cycle later at the earliest.
- IDLE: no capture. rd_v_o=0. arm_i clears both pointers, count_o and drop_cnt_o, latches mode_i, and moves to ARMED.
- ARMED, stream mode:
  - Behaves as a FIFO. rd_v_o = count_o!=0.
  - Full with no pop in the same cycle: the record is dropped and drop_cnt_o increments (saturating at all-ones).
  - Full with a push and a pop in the same cycle: both are accepted; count is unchanged.
  - Stream mode never leaves ARMED except via disarm_i.
- ARMED, trigger mode:
  - rd_v_o=0.
  - When full, a capture overwrites the oldest entry: rd_pointer advances and count stays depth_p.
  - A capture with retire_pc_i==trig_pc_i stores the trigger record. If post_count_i==0 the next state is FROZEN; otherwise the post counter loads post_count_i and the next state is POST.
- POST:
  - Each capture uses the same overwrite rule and decrements the post counter.
  - The capture that decrements it to 0 moves the state to FROZEN.
  - Further PC matches are ignored.
- FROZEN:
  - No capture. rd_v_o = count_o!=0. Each rd_yumi_i pops one record.
  - A pop that empties the buffer moves the state to IDLE. FROZEN with count 0 on entry is impossible (the trigger record is always stored).
- disarm_i has priority over every other event in the same cycle: state goes to IDLE and pointers/count clear; drop_cnt_o is held until the next arm.
- rd_yumi_i while rd_v_o=0 is illegal; it must be flagged by a simulation-only assertion, and RTL ignores it.
- Pointers are clog2(depth_p) bits wide and wrap naturally. count_o is the authoritative full/empty indicator.

Decomposition:
- Package bsg_vanilla_trace_pkg holds:
  - trace_state_e (IDLE, ARMED, POST, FROZEN)
  - trace_mode_e
  - the parametrised record layout function, which returns trace_rec_width
- Storage is one sub-module, bsg_mem_1r1w, instantiated with depth_p entries, asynchronous read and read-write bypass disabled.
- FSM, pointers, counters and the stall counter stay in the top module.

Test Plan:
- Stream mode, depth_p=4:
  - Retire PCs 0x100,0x104,0x108 with int writes x5=0x11,x6=0x22,x7=0x33, no yumi -> count_o=3, rd_data_o pc=0x100 wb0 addr 5 data 0x11.
  - Pop 3 -> count_o=0, rd_v_o=0.
- Stream mode full, depth_p=4:
  - 6 retires, no pops -> count_o=4, drop_cnt_o=2.
  - Full with push+pop in the same cycle -> count stays 4, drop_cnt unchanged.
- Trigger mode, depth_p=4, trig_pc=0x200, post_count=2, 10 retires at PCs 0x1F0..0x214 step 4 -> FROZEN after PC 0x208. Readout order is 0x1FC,0x200,0x204,0x208, then state IDLE.
- Stall count: 5 stall cycles then a retire -> record stall_cnt=5. With stall_cnt_width_p=3 and 10 stall cycles -> 7 (saturated).
- disarm_i in POST, issued in the same cycle as a retire -> state IDLE, count_o=0, no capture. Assert reset_n_i mid-POST -> all outputs at reset values immediately, without waiting for a clock edge.
